cntr_updn_n: RTL and testbench
==============================

// Module: cntr_updn_n
// PURPOSE
// - Parametrised up/down modulo counter with synchronous load, generalising the 8-bit inc/load counter.
// - Adds down-count, programmable step, programmable modulus and a wrap/limit flag.
// - Registered FSM state is exported for debug and bench checking.
// - Used as a general event/position counter feeding the shifter and display paths.
// PARAMETERS
// - WIDTH    8    counter width in bits (2..16)
// - MAX_VAL  255  highest count value; count range 0..MAX_VAL; must be < 2**WIDTH
// - STEP     1    increment/decrement amount; 1 <= STEP <= MAX_VAL
// PORTS
// - clk      in   1      rising-edge clock
// - reset_n  in   1      asynchronous active-low reset
// - inc      in   1      count up by STEP this cycle
// - dec      in   1      count down by STEP this cycle
// - load     in   1      load d_in this cycle (highest priority)
// - d_in     in   WIDTH  load value
// - d_out    out  WIDTH  current count (registered)
// - o_state  out  3      current FSM state (registered)
// - o_wrap   out  1      one-cycle flag: the last step wrapped (or hit a limit with SATURATE_EN)
// BEHAVIOUR
// - Reset (async, reset_n=0): d_out=0, o_state=IDLE, o_wrap=0; takes effect immediately, including mid-count.
// - States (o_state encoding): IDLE=3'b000, LOAD=3'b001, INC=3'b010, DEC=3'b011, CLASH=3'b100.
// - next_state is decoded combinationally from the inputs every cycle; there are no multi-cycle sequences:
//   - load=1 -> LOAD
//   - else inc=1 & dec=1 -> CLASH
//   - else inc=1 -> INC
//   - else dec=1 -> DEC
//   - else -> IDLE
// - At each rising clk: o_state <= next_state; d_out updated per next_state (1-cycle latency, input to d_out):
//   - LOAD: d_out <= d_in if d_in <= MAX_VAL, else d_out <= MAX_VAL (clamp).
//   - INC: if d_out + STEP <= MAX_VAL then d_out + STEP, else d_out + STEP - (MAX_VAL+1) (wrap).
//   - DEC: if d_out >= STEP then d_out - STEP, else d_out + (MAX_VAL+1) - STEP (wrap).
//   - IDLE, CLASH: d_out holds.
// - Arithmetic: all sums and compares are done at WIDTH+1 bits so nothing overflows before the wrap test.
// - o_wrap <= 1 only in the cycle following an INC or DEC step that wrapped; otherwise 0.
//   - o_wrap is never set by LOAD, including a clamped load.
// - load plus inc and/or dec: load wins; inc/dec are ignored that cycle.
// - reset_n release: first count action occurs at the first rising clk with reset_n=1.
// CONFIGURATION
// - SATURATE_EN defined:
//   - INC where d_out + STEP > MAX_VAL sets d_out <= MAX_VAL.
//   - DEC where d_out < STEP sets d_out <= 0.
//   - o_wrap (limit flag) <= 1 in the next cycle whenever a step was limited.
//     This includes a step attempted while already at the bound (d_out unchanged).
// - SATURATE_EN undefined: modulo wrap as above (default build).
// TESTING
// - Reset: reset_n=0 with inc=1 -> d_out=0, o_state=000, o_wrap=0; release, inc=1 x5 -> d_out=5, o_state=010.
// - Wrap up (MAX_VAL=9, STEP=3): load 8, inc -> d_out=1, o_wrap=1 for one cycle; inc -> 4, o_wrap=0.
// - Wrap down (MAX_VAL=9, STEP=3): load 1, dec -> d_out=8, o_wrap=1; dec -> 5, o_wrap=0.
// - Priority: load=1 inc=1 dec=1, d_in=8'h44 -> d_out=8'h44, o_state=001.
//   - Then inc=dec=1 -> d_out holds 8'h44, o_state=100.
// - Clamp: MAX_VAL=99, load d_in=200 -> d_out=99, o_wrap=0; async reset mid-count (inc=1) -> d_out=0 immediately.
// - SATURATE_EN (MAX_VAL=9, STEP=3): load 8, inc -> d_out=9, o_wrap=1; inc -> 9, o_wrap=1.
//   - load 2, dec -> d_out=0, o_wrap=1.

Source files
------------

// File: rtl/cntr_updn_n.sv
// Parametrised up/down modulo counter with synchronous load, step, modulus and wrap flag.
// Build option: define SATURATE_EN to clamp at 0/MAX_VAL instead of wrapping (o_wrap then flags the limit).
module cntr_updn_n #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 255,
   parameter int STEP    = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic [2:0]       o_state,
   output logic             o_wrap
);

   localparam logic [2:0] ST_IDLE  = 3'b000;
   localparam logic [2:0] ST_LOAD  = 3'b001;
   localparam logic [2:0] ST_INC   = 3'b010;
   localparam logic [2:0] ST_DEC   = 3'b011;
   localparam logic [2:0] ST_CLASH = 3'b100;

   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MAX_VAL + 1);

   // Count is held one bit wider so every sum and compare runs at WIDTH+1 bits;
   // the top bit is always zero between clocks.
   logic [WIDTH:0] count_reg;
   logic [WIDTH:0] count_next;
   logic [2:0]     state_reg;
   logic [2:0]     state_next;
   logic           wrap_reg;
   logic           wrap_next;

   logic [WIDTH:0] load_w;
   logic [WIDTH:0] sum_up;
   logic [WIDTH:0] diff_dn;
   logic [WIDTH:0] wrap_dn;
   logic           up_over;
   logic           dn_under;

   always_comb begin
      state_next = ST_IDLE;
      if (load)
         state_next = ST_LOAD;
      else if (inc && dec)
         state_next = ST_CLASH;
      else if (inc)
         state_next = ST_INC;
      else if (dec)
         state_next = ST_DEC;
   end

   always_comb begin
      load_w   = {1'b0, d_in};
      sum_up   = count_reg + STEP_W;
      diff_dn  = count_reg - STEP_W;
      wrap_dn  = count_reg + MOD_W - STEP_W;
      up_over  = (sum_up > MAX_W);
      dn_under = (count_reg < STEP_W);
   end

   always_comb begin
      count_next = count_reg;
      wrap_next  = 1'b0;
      case (state_next)
         ST_LOAD: begin
            count_next = (load_w > MAX_W) ? MAX_W : load_w;
         end
         ST_INC: begin
            wrap_next = up_over;
`ifdef SATURATE_EN
            count_next = up_over ? MAX_W : sum_up;
`else
            count_next = up_over ? (sum_up - MOD_W) : sum_up;
`endif
         end
         ST_DEC: begin
            wrap_next = dn_under;
`ifdef SATURATE_EN
            count_next = dn_under ? '0 : diff_dn;
`else
            count_next = dn_under ? wrap_dn : diff_dn;
`endif
         end
         default: begin
            count_next = count_reg;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         state_reg <= ST_IDLE;
         wrap_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         state_reg <= state_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign d_out   = count_reg[WIDTH-1:0];
   assign o_state = state_reg;
   assign o_wrap  = wrap_reg;

endmodule

// File: tb/tb_cntr_updn_n.sv
// Directed bench for cntr_updn_n: three parameter sets share one stimulus stream.
module tb_cntr_updn_n;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       inc, dec, load;
   logic [7:0] d_in;

   logic [7:0] def_out, m9_out, m99_out;
   logic [2:0] def_state, m9_state, m99_state;
   logic       def_wrap, m9_wrap, m99_wrap;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cntr_updn_n #(.WIDTH(8), .MAX_VAL(255), .STEP(1)) u_def (
      .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .load(load), .d_in(d_in),
      .d_out(def_out), .o_state(def_state), .o_wrap(def_wrap));

   cntr_updn_n #(.WIDTH(8), .MAX_VAL(9), .STEP(3)) u_m9 (
      .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .load(load), .d_in(d_in),
      .d_out(m9_out), .o_state(m9_state), .o_wrap(m9_wrap));

   cntr_updn_n #(.WIDTH(8), .MAX_VAL(99), .STEP(1)) u_m99 (
      .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .load(load), .d_in(d_in),
      .d_out(m99_out), .o_state(m99_state), .o_wrap(m99_wrap));

   task automatic check(input string tag, input int observed, input int expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end else begin
         $display("[TB] ok   %s: %0d", tag, observed);
      end
   endtask

   // Apply inputs, then sample on the following falling edge (one rising edge later).
   task automatic step(input logic l, input logic i, input logic d, input logic [7:0] v);
      load = l; inc = i; dec = d; d_in = v;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b1; inc = 1'b1; dec = 1'b0; load = 1'b0; d_in = 8'h00;
      #1 reset_n = 1'b0;
      #2;
      check("reset_dout", def_out, 0);
      check("reset_state", def_state, 3'b000);
      check("reset_wrap", def_wrap, 0);
      repeat (2) @(negedge clk);
      check("reset_hold_inc", def_out, 0);

      reset_n = 1'b1;
      repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00);
      check("inc_x5_dout", def_out, 5);
      check("inc_x5_state", def_state, 3'b010);

      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("idle_hold", def_out, 5);
      check("idle_state", def_state, 3'b000);

      step(1'b1, 1'b0, 1'b0, 8'd8);
      check("m9_load8", m9_out, 8);
      check("m9_load_state", m9_state, 3'b001);
      step(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef SATURATE_EN
      check("m9_inc_sat", m9_out, 9);
      check("m9_inc_sat_flag", m9_wrap, 1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("m9_inc_at_max", m9_out, 9);
      check("m9_inc_at_max_flag", m9_wrap, 1);
`else
      check("m9_inc_wrap", m9_out, 1);
      check("m9_inc_wrap_flag", m9_wrap, 1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("m9_inc_next", m9_out, 4);
      check("m9_inc_next_flag", m9_wrap, 0);
`endif

      step(1'b1, 1'b0, 1'b0, 8'd1);
      check("m9_load1", m9_out, 1);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("m9_dec_state", m9_state, 3'b011);
      check("m9_dec_flag", m9_wrap, 1);
`ifdef SATURATE_EN
      check("m9_dec_sat", m9_out, 0);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("m9_dec_at_min", m9_out, 0);
      check("m9_dec_at_min_flag", m9_wrap, 1);
`else
      check("m9_dec_wrap", m9_out, 8);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("m9_dec_next", m9_out, 5);
      check("m9_dec_next_flag", m9_wrap, 0);
`endif

      step(1'b1, 1'b1, 1'b1, 8'h44);
      check("prio_load_dout", def_out, 8'h44);
      check("prio_load_state", def_state, 3'b001);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("clash_hold", def_out, 8'h44);
      check("clash_state", def_state, 3'b100);
      check("clash_wrap", def_wrap, 0);

      step(1'b1, 1'b0, 1'b0, 8'd200);
      check("m99_clamp", m99_out, 99);
      check("m99_clamp_wrap", m99_wrap, 0);
      check("def_load200", def_out, 200);
      step(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef SATURATE_EN
      check("m99_inc_top", m99_out, 99);
`else
      check("m99_inc_top", m99_out, 0);
`endif
      check("m99_inc_top_flag", m99_wrap, 1);

      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef SATURATE_EN
      check("def_dec_zero", def_out, 0);
`else
      check("def_dec_zero", def_out, 255);
`endif
      check("def_dec_zero_flag", def_wrap, 1);

      step(1'b1, 1'b0, 1'b0, 8'd10);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("def_mid_count", def_out, 11);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_dout", def_out, 0);
      check("async_rst_state", def_state, 3'b000);
      check("async_rst_m99", m99_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("post_rst_inc", def_out, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
